// File: rtl/vga_pattern_gen_pkg.sv
// Shared pattern enum, pixel struct and colour-bar table for the VGA pattern generator.
package vga_pkg;

   localparam int COLOR_W = 4;

   typedef enum logic [1:0] {
      QUAD  = 2'd0,
      BARS  = 2'd1,
      CHECK = 2'd2,
      SOLID = 2'd3
   } pattern_e;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   // {R,G,B} on/off mask per bar, bar 0 (white) in the low slot, bar 7 (black) in the high slot.
   localparam logic [7:0][2:0] BAR_TABLE = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

endpackage

// File: rtl/vga_pattern_gen_timing.sv
// Pixel-rate divider, horizontal/vertical counters and raw sync/active decode.
module vga_timing #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter int CLK_DIV  = 2,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic          o_tick,
   output logic [HW-1:0] o_h,
   output logic [VW-1:0] o_v,
   output logic          o_hSyncOn,
   output logic          o_vSyncOn,
   output logic          o_active,
   output logic          o_firstPixel
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] r_div;
   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;

   assign o_tick = (r_div == DW'(CLK_DIV - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_div <= '0;
         r_h   <= '0;
         r_v   <= '0;
      end else if (o_tick) begin
         r_div <= '0;
         if (r_h == HW'(H_TOTAL - 1)) begin
            r_h <= '0;
            if (r_v == VW'(V_TOTAL - 1)) begin
               r_v <= '0;
            end else begin
               r_v <= r_v + 1'b1;
            end
         end else begin
            r_h <= r_h + 1'b1;
         end
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign o_h          = r_h;
   assign o_v          = r_v;
   assign o_hSyncOn    = (r_h >= HW'(H_ACTIVE + H_FP)) && (r_h <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
   assign o_vSyncOn    = (r_v >= VW'(V_ACTIVE + V_FP)) && (r_v <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
   assign o_active     = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
   assign o_firstPixel = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four runtime-selectable test patterns; every output is registered
// on the pixel tick and describes the pixel whose counters were current at that tick.
module vga_pattern_gen #(
   parameter int   H_ACTIVE   = 800,
   parameter int   H_FP       = 56,
   parameter int   H_SYNC     = 120,
   parameter int   H_BP       = 64,
   parameter int   V_ACTIVE   = 600,
   parameter int   V_FP       = 37,
   parameter int   V_SYNC     = 6,
   parameter int   V_BP       = 23,
   parameter logic HSYNC_POL  = 1'b0,
   parameter logic VSYNC_POL  = 1'b0,
   parameter int   CLK_DIV    = 2,
   parameter int   COLOR_W    = 4,
   parameter int   CHECK_LOG2 = 5,
   localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  HW         = $clog2(H_TOTAL),
   localparam int  VW         = $clog2(V_TOTAL)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [1:0]           i_mode,
   input  logic [3*COLOR_W-1:0] i_fgColor,
   output logic                 o_hsync,
   output logic                 o_vsync,
   output logic [COLOR_W-1:0]   o_red,
   output logic [COLOR_W-1:0]   o_green,
   output logic [COLOR_W-1:0]   o_blue,
   output logic                 o_de,
   output logic                 o_frameStart,
   output logic [HW-1:0]        o_hcount,
   output logic [VW-1:0]        o_vcount
);

   import vga_pkg::*;

   localparam logic [COLOR_W-1:0] MAX  = '1;
   localparam logic [COLOR_W-1:0] HALF = COLOR_W'(1 << (COLOR_W - 1));
   localparam int                 BAR_W = H_ACTIVE / 8;

   logic          w_tick;
   logic [HW-1:0] w_h;
   logic [VW-1:0] w_v;
   logic          w_hSyncOn;
   logic          w_vSyncOn;
   logic          w_active;
   logic          w_firstPixel;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .CLK_DIV  (CLK_DIV)
   ) u_timing (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .o_tick       (w_tick),
      .o_h          (w_h),
      .o_v          (w_v),
      .o_hSyncOn    (w_hSyncOn),
      .o_vSyncOn    (w_vSyncOn),
      .o_active     (w_active),
      .o_firstPixel (w_firstPixel)
   );

   pattern_e             r_mode;
   logic [3*COLOR_W-1:0] r_fg;
   pattern_e             w_mode;
   logic [3*COLOR_W-1:0] w_fg;
   logic [2:0]           w_barIdx;
   logic [2:0]           w_barMask;
   logic                 w_checkOn;
   logic                 w_left;
   logic                 w_top;
   logic [COLOR_W-1:0]   w_r;
   logic [COLOR_W-1:0]   w_g;
   logic [COLOR_W-1:0]   w_b;

   // The frame's first pixel already uses the newly sampled mode and colour.
   assign w_mode    = w_firstPixel ? pattern_e'(i_mode) : r_mode;
   assign w_fg      = w_firstPixel ? i_fgColor : r_fg;
   assign w_barIdx  = (w_h >= HW'(7 * BAR_W)) ? 3'd7 : 3'(w_h / HW'(BAR_W));
   assign w_barMask = BAR_TABLE[w_barIdx];
   assign w_checkOn = w_h[CHECK_LOG2] ^ w_v[CHECK_LOG2];
   assign w_left    = (w_h < HW'(H_ACTIVE / 2));
   assign w_top     = (w_v < VW'(V_ACTIVE / 2));

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (w_active) begin
         case (w_mode)
            QUAD: begin
               if (w_top && w_left) begin
                  w_r = HALF;
               end else if (w_top) begin
                  w_g = HALF;
               end else if (w_left) begin
                  w_b = HALF;
               end else begin
                  w_r = HALF;
                  w_g = HALF;
               end
            end
            BARS: begin
               w_r = w_barMask[2] ? MAX : '0;
               w_g = w_barMask[1] ? MAX : '0;
               w_b = w_barMask[0] ? MAX : '0;
            end
            CHECK: begin
               if (w_checkOn) begin
                  {w_r, w_g, w_b} = w_fg;
               end
            end
            default: begin
               {w_r, w_g, w_b} = w_fg;
            end
         endcase
      end
   end

   logic               r_hsync;
   logic               r_vsync;
   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_green;
   logic [COLOR_W-1:0] r_blue;
   logic               r_de;
   logic               r_frameStart;
   logic [HW-1:0]      r_hcount;
   logic [VW-1:0]      r_vcount;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_mode       <= QUAD;
         r_fg         <= '0;
         r_hsync      <= ~HSYNC_POL;
         r_vsync      <= ~VSYNC_POL;
         r_red        <= '0;
         r_green      <= '0;
         r_blue       <= '0;
         r_de         <= 1'b0;
         r_frameStart <= 1'b0;
         r_hcount     <= '0;
         r_vcount     <= '0;
      end else begin
         r_frameStart <= 1'b0;
         if (w_tick) begin
            if (w_firstPixel) begin
               r_mode <= pattern_e'(i_mode);
               r_fg   <= i_fgColor;
            end
            r_hsync      <= w_hSyncOn ? HSYNC_POL : ~HSYNC_POL;
            r_vsync      <= w_vSyncOn ? VSYNC_POL : ~VSYNC_POL;
            r_red        <= w_r;
            r_green      <= w_g;
            r_blue       <= w_b;
            r_de         <= w_active;
            r_frameStart <= w_firstPixel;
            r_hcount     <= w_h;
            r_vcount     <= w_v;
         end
      end
   end

   assign o_hsync      = r_hsync;
   assign o_vsync      = r_vsync;
   assign o_red        = r_red;
   assign o_green      = r_green;
   assign o_blue       = r_blue;
   assign o_de         = r_de;
   assign o_frameStart = r_frameStart;
   assign o_hcount     = r_hcount;
   assign o_vcount     = r_vcount;

endmodule
